dmb_cnt_monitor: RTL and testbench



---
 rtl/dmb_cnt_monitor_pkg.sv | 21 ++
 rtl/dmb_cnt_monitor_if.sv | 22 ++
 rtl/dmb_cnt_monitor_sat_counter.sv | 23 ++
 rtl/dmb_cnt_monitor.sv | 112 +++++++++++
 tb/tb_dmb_cnt_monitor.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmb_cnt_monitor_pkg.sv
// dmb_cnt_monitor shared package: state codes and widths.
// Statistics ports are compiled in with CNT_MON_STATS_EN.
package cnt_mon_pkg;

  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OK    = 2'd1,
    ST_WARN  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dmb_cnt_monitor_if.sv
// dmb_cnt_monitor event bus: strobed count and expected count.
// Master is the bit-counter stage, slave is the monitor.
interface dmb_cnt_monitor_if;
  import cnt_mon_pkg::*;

  logic [CNT_W-1:0] CNT_IN;
  logic             CNT_VLD;
  logic [CNT_W-1:0] EXP_CNT;

  modport master (
    output CNT_IN,
    output CNT_VLD,
    output EXP_CNT
  );

  modport slave (
    input CNT_IN,
    input CNT_VLD,
    input EXP_CNT
  );

endinterface

// File: rtl/dmb_cnt_monitor_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/dmb_cnt_monitor.sv
// dmb_cnt_monitor: per-event live-count check with WARN/ERR persistence.
// Define CNT_MON_STATS_EN to add EV_CNT/MIS_CNT statistics.
module dmb_cnt_monitor
  import cnt_mon_pkg::*;
#(
  parameter int WARN_THR = 2,
  parameter int ERR_THR  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  dmb_cnt_monitor_if.slave  ev,
  output logic [1:0]        STATE,
  output logic              WARN,
  output logic              ERR,
  output logic [4:0]        DELTA,
  output logic [CNT_W-1:0]  RUN_LEN,
  output logic [CNT_W-1:0]  MAX_CNT
`ifdef CNT_MON_STATS_EN
  ,
  output logic [STAT_W-1:0] EV_CNT,
  output logic [STAT_W-1:0] MIS_CNT
`endif
);

  localparam logic [CNT_W-1:0] WTHR = CNT_W'(WARN_THR);
  localparam logic [CNT_W-1:0] ETHR = CNT_W'(ERR_THR);

  state_e           st_q;
  state_e           st_d;
  logic             acc;
  logic             hit;
  logic             miss;
  logic [CNT_W-1:0] run_nx;

  assign acc    = ev.CNT_VLD & ~CLR;
  assign hit    = acc & (ev.CNT_IN == ev.EXP_CNT);
  assign miss   = acc & (ev.CNT_IN != ev.EXP_CNT);
  assign run_nx = sat_inc(RUN_LEN);

  sat_counter #(.W(CNT_W)) u_run (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (CLR | hit),
    .inc   (miss),
    .q     (RUN_LEN)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Thresholds are judged on the run length this event produces.
  always_comb begin
    st_d = st_q;
    unique case (1'b1)
      CLR: st_d = ST_IDLE;
      hit: begin
        if (st_q != ST_ERROR) st_d = ST_OK;
      end
      miss: begin
        if (st_q == ST_ERROR || run_nx >= ETHR)
          st_d = ST_ERROR;
        else if (run_nx >= WTHR || st_q == ST_WARN)
          st_d = ST_WARN;
        else
          st_d = ST_OK;
      end
      default: ;
    endcase
  end

  assign STATE = st_q;
  assign WARN  = (st_q == ST_WARN);
  assign ERR   = (st_q == ST_ERROR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DELTA   <= '0;
      MAX_CNT <= '0;
    end else if (CLR) begin
      DELTA   <= '0;
      MAX_CNT <= '0;
    end else if (acc) begin
      DELTA <= {1'b0, ev.CNT_IN} - {1'b0, ev.EXP_CNT};
      if (ev.CNT_IN > MAX_CNT) MAX_CNT <= ev.CNT_IN;
    end
  end

`ifdef CNT_MON_STATS_EN
  sat_counter #(.W(STAT_W)) u_ev (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (CLR),
    .inc   (acc),
    .q     (EV_CNT)
  );

  sat_counter #(.W(STAT_W)) u_mis (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (CLR),
    .inc   (miss),
    .q     (MIS_CNT)
  );
`endif

endmodule

// File: tb/tb_dmb_cnt_monitor.sv
// Testbench for dmb_cnt_monitor: directed scenarios plus random run.
// Two instances: default thresholds, and WARN_THR=1/ERR_THR=15.
module tb_dmb_cnt_monitor;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic CLR = 1'b0;

  dmb_cnt_monitor_if bus();

  logic [1:0] sA, sB;
  logic       wA, wB, eA, eB;
  logic [4:0] dA, dB;
  logic [3:0] rA, rB, mA, mB;
`ifdef CNT_MON_STATS_EN
  logic [15:0] evA, evB, misA, misB;
`endif

  int checks = 0;
  int errors = 0;

  int m_st[2];
  int m_run[2];
  int m_dl, m_mx, m_ev, m_mis;
  int wthr[2] = '{2, 1};
  int ethr[2] = '{8, 15};

  dmb_cnt_monitor #(.WARN_THR(2), .ERR_THR(8)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .ev(bus),
    .STATE(sA), .WARN(wA), .ERR(eA), .DELTA(dA),
    .RUN_LEN(rA), .MAX_CNT(mA)
`ifdef CNT_MON_STATS_EN
    , .EV_CNT(evA), .MIS_CNT(misA)
`endif
  );

  dmb_cnt_monitor #(.WARN_THR(1), .ERR_THR(15)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .ev(bus),
    .STATE(sB), .WARN(wB), .ERR(eB), .DELTA(dB),
    .RUN_LEN(rB), .MAX_CNT(mB)
`ifdef CNT_MON_STATS_EN
    , .EV_CNT(evB), .MIS_CNT(misB)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i]  = 0;
      m_run[i] = 0;
    end
    m_dl = 0; m_mx = 0; m_ev = 0; m_mis = 0;
  endfunction

  function automatic void model_step(logic v, int c, int e, logic cl);
    if (cl) begin
      model_reset();
      return;
    end
    if (!v) return;
    m_dl = c - e;
    if (c > m_mx) m_mx = c;
    if (m_ev < 65535) m_ev++;
    if (c != e && m_mis < 65535) m_mis++;
    for (int i = 0; i < 2; i++) begin
      if (c == e) begin
        m_run[i] = 0;
        if (m_st[i] != 3) m_st[i] = 1;
      end else begin
        if (m_run[i] < 15) m_run[i]++;
        if (m_st[i] == 3 || m_run[i] >= ethr[i]) m_st[i] = 3;
        else if (m_run[i] >= wthr[i] || m_st[i] == 2) m_st[i] = 2;
        else m_st[i] = 1;
      end
    end
  endfunction

  task automatic cycle(input logic v, input int c, input int e, input logic cl);
    @(negedge CLK);
    bus.CNT_VLD = v;
    bus.CNT_IN  = 4'(c);
    bus.EXP_CNT = 4'(e);
    CLR         = cl;
    @(posedge CLK);
    model_step(v, c, e, cl);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CLR = 1'b0;
    bus.CNT_VLD = 1'b0; bus.CNT_IN = '0; bus.EXP_CNT = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (sA !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", sA); end
    checks++; if ({wA, eA} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {wA, eA}); end
    checks++; if (dA !== 5'd0) begin errors++; $display("FAIL reset_delta got %0d exp 0", dA); end
    checks++; if ({rA, mA} !== 8'd0) begin errors++; $display("FAIL reset_run_max got %h exp 00", {rA, mA}); end
    checks++; if (sB !== 2'd0) begin errors++; $display("FAIL reset_state_b got %0d exp 0", sB); end
`ifdef CNT_MON_STATS_EN
    checks++; if ({evA, misA} !== 32'd0) begin errors++; $display("FAIL reset_stats got %h exp 0", {evA, misA}); end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic test_match();
    repeat (5) cycle(1'b1, 12, 12, 1'b0);
    checks++; if (sA !== 2'd1) begin errors++; $display("FAIL match_state got %0d exp 1", sA); end
    checks++; if (rA !== 4'd0) begin errors++; $display("FAIL match_run got %0d exp 0", rA); end
    checks++; if (dA !== 5'd0) begin errors++; $display("FAIL match_delta got %0d exp 0", dA); end
    checks++; if (mA !== 4'd12) begin errors++; $display("FAIL match_max got %0d exp 12", mA); end
    checks++; if (sB !== 2'd1) begin errors++; $display("FAIL match_state_b got %0d exp 1", sB); end
`ifdef CNT_MON_STATS_EN
    checks++; if (evA !== 16'd5) begin errors++; $display("FAIL match_ev got %0d exp 5", evA); end
    checks++; if (misA !== 16'd0) begin errors++; $display("FAIL match_mis got %0d exp 0", misA); end
`endif
  endtask

  task automatic test_warn();
    cycle(1'b1, 10, 12, 1'b0);
    checks++; if (sA !== 2'd1) begin errors++; $display("FAIL warn1_state got %0d exp 1", sA); end
    checks++; if (rA !== 4'd1) begin errors++; $display("FAIL warn1_run got %0d exp 1", rA); end
    checks++; if (sB !== 2'd2) begin errors++; $display("FAIL warn1_state_b got %0d exp 2", sB); end
    cycle(1'b1, 10, 12, 1'b0);
    checks++; if (sA !== 2'd2 || wA !== 1'b1) begin errors++; $display("FAIL warn2_state got %0d/%b exp 2/1", sA, wA); end
    checks++; if (dA !== 5'b11110) begin errors++; $display("FAIL warn2_delta got %b exp 11110", dA); end
    cycle(1'b1, 12, 12, 1'b0);
    checks++; if (sA !== 2'd1 || wA !== 1'b0) begin errors++; $display("FAIL warn3_state got %0d/%b exp 1/0", sA, wA); end
    checks++; if (rA !== 4'd0) begin errors++; $display("FAIL warn3_run got %0d exp 0", rA); end
    checks++; if (sB !== 2'd1) begin errors++; $display("FAIL warn3_state_b got %0d exp 1", sB); end
  endtask

  task automatic test_error();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 15, 0, 1'b0);
      if (i == 7) begin
        checks++; if (eA !== 1'b0) begin errors++; $display("FAIL err7_flag got %b exp 0", eA); end
      end
    end
    checks++; if (eA !== 1'b1 || sA !== 2'd3) begin errors++; $display("FAIL err8_flag got %b/%0d exp 1/3", eA, sA); end
    checks++; if (dA !== 5'd15) begin errors++; $display("FAIL err8_delta got %0d exp 15", dA); end
    cycle(1'b1, 3, 3, 1'b0);
    checks++; if (sA !== 2'd3 || eA !== 1'b1) begin errors++; $display("FAIL err_sticky got %0d/%b exp 3/1", sA, eA); end
    checks++; if (rA !== 4'd0) begin errors++; $display("FAIL err_run got %0d exp 0", rA); end
    cycle(1'b0, 0, 0, 1'b1);
    checks++; if ({sA, wA, eA, dA, rA, mA} !== 17'd0) begin errors++; $display("FAIL clr_all_a got %h exp 0", {sA, wA, eA, dA, rA, mA}); end
    checks++; if ({sB, wB, eB, dB, rB, mB} !== 17'd0) begin errors++; $display("FAIL clr_all_b got %h exp 0", {sB, wB, eB, dB, rB, mB}); end
`ifdef CNT_MON_STATS_EN
    checks++; if ({evA, misA} !== 32'd0) begin errors++; $display("FAIL clr_stats got %h exp 0", {evA, misA}); end
`endif
  endtask

  task automatic test_clr_collision();
    cycle(1'b1, 4, 9, 1'b0);
    checks++; if (sA !== 2'd1 || rA !== 4'd1) begin errors++; $display("FAIL coll_pre got %0d/%0d exp 1/1", sA, rA); end
    cycle(1'b1, 2, 7, 1'b1);
    checks++; if (sA !== 2'd0 || sB !== 2'd0) begin errors++; $display("FAIL coll_state got %0d/%0d exp 0/0", sA, sB); end
    checks++; if ({dA, rA, mA} !== 13'd0) begin errors++; $display("FAIL coll_regs got %h exp 0", {dA, rA, mA}); end
`ifdef CNT_MON_STATS_EN
    checks++; if (evA !== 16'd0) begin errors++; $display("FAIL coll_ev got %0d exp 0", evA); end
`endif
  endtask

  task automatic test_saturate();
    cycle(1'b0, 0, 0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 5, 3, 1'b0);
      if (i == 1) begin
        checks++; if (sB !== 2'd2) begin errors++; $display("FAIL sat1_state_b got %0d exp 2", sB); end
      end
      if (i == 14) begin
        checks++; if (sB !== 2'd2) begin errors++; $display("FAIL sat14_state_b got %0d exp 2", sB); end
      end
      if (i == 15) begin
        checks++; if (sB !== 2'd3 || eB !== 1'b1) begin errors++; $display("FAIL sat15_state_b got %0d/%b exp 3/1", sB, eB); end
      end
    end
    checks++; if (rA !== 4'd15 || rB !== 4'd15) begin errors++; $display("FAIL sat_run got %0d/%0d exp 15/15", rA, rB); end
    checks++; if (sA !== 2'd3) begin errors++; $display("FAIL sat_state_a got %0d exp 3", sA); end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b1, 9, 6, 1'b0);
    cycle(1'b1, 9, 6, 1'b0);
    checks++; if (wA !== 1'b1) begin errors++; $display("FAIL arst_pre got %b exp 1", wA); end
    @(negedge CLK);
    bus.CNT_VLD = 1'b0;
    RST_N = 1'b0;
    #1;
    checks++; if ({sA, wA, eA, dA, rA, mA} !== 17'd0) begin errors++; $display("FAIL arst_a got %h exp 0", {sA, wA, eA, dA, rA, mA}); end
    checks++; if ({sB, wB, eB, dB, rB, mB} !== 17'd0) begin errors++; $display("FAIL arst_b got %h exp 0", {sB, wB, eB, dB, rB, mB}); end
    model_reset();
    #1;
    RST_N = 1'b1;
    cycle(1'b1, 7, 7, 1'b0);
    checks++; if (sA !== 2'd1 || mA !== 4'd7 || rA !== 4'd0) begin errors++; $display("FAIL arst_post got %0d/%0d/%0d exp 1/7/0", sA, mA, rA); end
  endtask

  task automatic test_random();
    logic v, cl;
    int c, e;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 39) == 0);
      c  = $urandom_range(0, 15);
      e  = ($urandom_range(0, 2) == 0) ? c : $urandom_range(0, 15);
      cycle(v, c, e, cl);
      checks++;
      if ({sA, wA, eA, dA, rA, mA} !== {2'(m_st[0]), m_st[0] == 2, m_st[0] == 3, 5'(m_dl), 4'(m_run[0]), 4'(m_mx)}) begin
        errors++;
        $display("FAIL rand_a n=%0d got st%0d w%b e%b d%0d r%0d m%0d exp st%0d d%0d r%0d m%0d",
                 n, sA, wA, eA, dA, rA, mA, m_st[0], 5'(m_dl), m_run[0], m_mx);
      end
      checks++;
      if ({sB, wB, eB, dB, rB, mB} !== {2'(m_st[1]), m_st[1] == 2, m_st[1] == 3, 5'(m_dl), 4'(m_run[1]), 4'(m_mx)}) begin
        errors++;
        $display("FAIL rand_b n=%0d got st%0d w%b e%b d%0d r%0d m%0d exp st%0d d%0d r%0d m%0d",
                 n, sB, wB, eB, dB, rB, mB, m_st[1], 5'(m_dl), m_run[1], m_mx);
      end
`ifdef CNT_MON_STATS_EN
      checks++;
      if ({evA, misA, evB, misB} !== {16'(m_ev), 16'(m_mis), 16'(m_ev), 16'(m_mis)}) begin
        errors++;
        $display("FAIL rand_stats n=%0d got %0d/%0d exp %0d/%0d", n, evA, misA, m_ev, m_mis);
      end
`endif
    end
  endtask

`ifdef CNT_MON_STATS_EN
  task automatic test_ev_sat();
    cycle(1'b0, 0, 0, 1'b1);
    for (int n = 0; n < 65534; n++) cycle(1'b1, 1, 1, 1'b0);
    checks++; if (evA !== 16'hFFFE) begin errors++; $display("FAIL evsat_pre got %h exp fffe", evA); end
    repeat (3) cycle(1'b1, 1, 1, 1'b0);
    checks++; if (evA !== 16'hFFFF || evB !== 16'hFFFF) begin errors++; $display("FAIL evsat got %h/%h exp ffff", evA, evB); end
    cycle(1'b1, 2, 1, 1'b0);
    checks++; if (evA !== 16'hFFFF || misA !== 16'd1) begin errors++; $display("FAIL evsat_mis got %h/%0d exp ffff/1", evA, misA); end
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_warn();
    test_error();
    test_clr_collision();
    test_saturate();
    test_async_reset();
    test_random();
`ifdef CNT_MON_STATS_EN
    test_ev_sat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
